// File: rtl/tow_arena.sv
// Tug-of-war light game: two players push a single light toward their own end of the field.
// Define TOW_CPU_EN to replace player 2 with an LFSR-driven CPU opponent throttled by cpu_level.
module tow_arena #(
    parameter int FIELD       = 9,
    parameter int WIN_ROUNDS  = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              p1_in,
    input  logic                              p2_in,
    input  logic [3:0]                        cpu_level,
    output logic [FIELD-1:0]                  field,
    output logic [$clog2(WIN_ROUNDS+1)-1:0]   score1,
    output logic [$clog2(WIN_ROUNDS+1)-1:0]   score2,
    output logic                              round_over,
    output logic [1:0]                        match_winner
);

    localparam int PW     = (FIELD > 1) ? $clog2(FIELD) : 1;
    localparam int SW     = $clog2(WIN_ROUNDS + 1);
    localparam int HW     = $clog2(HOLD_CYCLES + 1);
    localparam int CENTER = (FIELD - 1) / 2;

    typedef enum logic [1:0] {PLAY, ROUND_END, MATCH_END} state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   pos_reg, pos_next;
    logic [HW-1:0]   hold_reg, hold_next;
    logic [SW-1:0]   score1_next, score2_next;
    logic [1:0]      match_winner_next;
    logic [FIELD-1:0] onehot_next, field_next;
    logic            round_over_next;
    logic            p1_q_reg, p2_q_reg;
    logic            p1_press, p2_press;

    assign p1_press = p1_in & ~p1_q_reg;

`ifdef TOW_CPU_EN
    logic [9:0] lfsr_reg;
    logic       unused_p2;

    // Fibonacci LFSR, taps 10 and 7; low nibble is a uniform-ish 0..15 draw.
    always_ff @(posedge clk) begin
        if (reset) lfsr_reg <= 10'h001;
        else       lfsr_reg <= {lfsr_reg[8:0], lfsr_reg[9] ^ lfsr_reg[6]};
    end

    assign p2_press  = (lfsr_reg[3:0] < cpu_level);
    assign unused_p2 = p2_in ^ p2_q_reg;
`else
    logic unused_cpu;

    assign p2_press   = p2_in & ~p2_q_reg;
    assign unused_cpu = ^cpu_level;
`endif

    always_comb begin
        state_next        = state_reg;
        pos_next          = pos_reg;
        hold_next         = hold_reg;
        score1_next       = score1;
        score2_next       = score2;
        match_winner_next = match_winner;
        case (state_reg)
            PLAY: begin
                if (p1_press && !p2_press) begin
                    if (pos_reg == '0) begin
                        if (score1 < SW'(WIN_ROUNDS)) score1_next = score1 + SW'(1);
                        hold_next = '0;
                        if (score1_next == SW'(WIN_ROUNDS)) begin
                            state_next        = MATCH_END;
                            match_winner_next = 2'b01;
                        end else begin
                            state_next = ROUND_END;
                        end
                    end else begin
                        pos_next = pos_reg - PW'(1);
                    end
                end else if (p2_press && !p1_press) begin
                    if (pos_reg == PW'(FIELD - 1)) begin
                        if (score2 < SW'(WIN_ROUNDS)) score2_next = score2 + SW'(1);
                        hold_next = '0;
                        if (score2_next == SW'(WIN_ROUNDS)) begin
                            state_next        = MATCH_END;
                            match_winner_next = 2'b10;
                        end else begin
                            state_next = ROUND_END;
                        end
                    end else begin
                        pos_next = pos_reg + PW'(1);
                    end
                end
            end
            ROUND_END: begin
                // The win edge itself is the first blank cycle, so count to HOLD_CYCLES-1.
                if (hold_reg == HW'(HOLD_CYCLES - 1)) begin
                    state_next = PLAY;
                    pos_next   = PW'(CENTER);
                end else begin
                    hold_next = hold_reg + HW'(1);
                end
            end
            MATCH_END: ;
            default: begin
                state_next = PLAY;
                pos_next   = PW'(CENTER);
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < FIELD; gi++) begin : g_decode
            assign onehot_next[gi] = (pos_next == PW'(gi));
        end
    endgenerate

    assign field_next      = (state_next == PLAY) ? onehot_next : '0;
    assign round_over_next = (state_next == ROUND_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= PLAY;
            pos_reg      <= PW'(CENTER);
            hold_reg     <= '0;
            p1_q_reg     <= 1'b0;
            p2_q_reg     <= 1'b0;
            field        <= FIELD'(1) << CENTER;
            score1       <= '0;
            score2       <= '0;
            round_over   <= 1'b0;
            match_winner <= 2'b00;
        end else begin
            state_reg    <= state_next;
            pos_reg      <= pos_next;
            hold_reg     <= hold_next;
            p1_q_reg     <= p1_in;
            p2_q_reg     <= p2_in;
            field        <= field_next;
            score1       <= score1_next;
            score2       <= score2_next;
            round_over   <= round_over_next;
            match_winner <= match_winner_next;
        end
    end

endmodule
